// File: rtl/f1_race_ctrl.sv
// F1 start-light controller with reaction timer.
// Runs a five-light style sequence (eight lights here): lights come on one per
// tick, hold for a pseudo-random number of ticks, go out, then the driver's
// reaction time is measured in clk cycles. Early reaction is a jump start.
module f1_race_ctrl #(
    parameter logic [15:0] TICK_DIV = 16'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger,
    input  logic        react,
    output logic [7:0]  lights,
    output logic [15:0] react_time,
    output logic        time_valid,
    output logic        jump_start,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LIGHTS,
        S_HOLD,
        S_GO,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] tick_q, tick_d;
    logic [7:0]  lights_q, lights_d;
    logic [6:0]  hold_q, hold_d;
    logic [15:0] react_cnt_q, react_cnt_d;
    logic [15:0] react_time_q, react_time_d;
    logic        time_valid_q, time_valid_d;
    logic        jump_q, jump_d;
    logic [6:0]  lfsr_q, lfsr_d;
    logic        tick;

    assign tick = (tick_q == TICK_DIV - 16'd1);

    // Next-state and datapath updates for the light sequence and timer.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d      = state_q;
        tick_d       = tick_q;
        lights_d     = lights_q;
        hold_d       = hold_q;
        react_cnt_d  = react_cnt_q;
        react_time_d = react_time_q;
        time_valid_d = 1'b0;
        jump_d       = jump_q;
        lfsr_d       = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[2]};

        case (state_q)
            S_IDLE, S_DONE: begin
                // A start request beats a simultaneous button press here.
                if (trigger) begin
                    state_d     = S_LIGHTS;
                    tick_d      = 16'd0;
                    lights_d    = 8'h00;
                    jump_d      = 1'b0;
                    react_cnt_d = 16'd0;
                end
            end
            S_LIGHTS: begin
                if (react) begin
                    jump_d   = 1'b1;
                    lights_d = 8'h00;
                    state_d  = S_DONE;
                end else if (tick) begin
                    tick_d   = 16'd0;
                    lights_d = {lights_q[6:0], 1'b1};
                    if (lights_q == 8'h7F) begin
                        state_d = S_HOLD;
                        hold_d  = lfsr_q;
                    end
                end else begin
                    tick_d = tick_q + 16'd1;
                end
            end
            S_HOLD: begin
                // A press on the very tick that would release the lights is still early.
                if (react) begin
                    jump_d   = 1'b1;
                    lights_d = 8'h00;
                    state_d  = S_DONE;
                end else if (tick) begin
                    tick_d = 16'd0;
                    hold_d = hold_q - 7'd1;
                    if (hold_q == 7'd1) begin
                        state_d     = S_GO;
                        lights_d    = 8'h00;
                        react_cnt_d = 16'd0;
                    end
                end else begin
                    tick_d = tick_q + 16'd1;
                end
            end
            S_GO: begin
                if (react) begin
                    react_time_d = react_cnt_q;
                    time_valid_d = 1'b1;
                    state_d      = S_DONE;
                end else if (react_cnt_q != 16'hFFFF) begin
                    react_cnt_d = react_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset taking priority over all inputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q      <= S_IDLE;
            tick_q       <= 16'd0;
            lights_q     <= 8'h00;
            hold_q       <= 7'd0;
            react_cnt_q  <= 16'd0;
            react_time_q <= 16'd0;
            time_valid_q <= 1'b0;
            jump_q       <= 1'b0;
            lfsr_q       <= 7'h01;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            lights_q     <= lights_d;
            hold_q       <= hold_d;
            react_cnt_q  <= react_cnt_d;
            react_time_q <= react_time_d;
            time_valid_q <= time_valid_d;
            jump_q       <= jump_d;
            lfsr_q       <= lfsr_d;
        end
    end

    assign lights     = lights_q;
    assign react_time = react_time_q;
    assign time_valid = time_valid_q;
    assign jump_start = jump_q;
    assign busy       = (state_q == S_LIGHTS) || (state_q == S_HOLD) || (state_q == S_GO);

endmodule

// File: tb/tb_f1_race_ctrl.sv
// Self-checking bench for f1_race_ctrl with TICK_DIV=4.
// Expected light patterns come from elapsed cycles, hold length from an
// LFSR model, and reaction times from the cycle at which react is driven.
module tb_f1_race_ctrl;

    localparam logic [15:0] TD = 16'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trigger = 1'b0;
    logic        react = 1'b0;
    logic [7:0]  lights;
    logic [15:0] react_time;
    logic        time_valid;
    logic        jump_start;
    logic        busy;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] last_rt = 16'd0;

    // Reference pseudo-random source and the value it held just before the latest edge.
    logic [6:0]  lfsr_m = 7'h01;
    logic [6:0]  lfsr_pre = 7'h01;

    f1_race_ctrl #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst        (rst),
        .trigger    (trigger),
        .react      (react),
        .lights     (lights),
        .react_time (react_time),
        .time_valid (time_valid),
        .jump_start (jump_start),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference LFSR: one step per clock, forced to 1 by reset.
    always @(posedge clk) begin
        lfsr_pre <= lfsr_m;
        lfsr_m   <= rst ? 7'h01 : {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[2]};
    end

    function automatic logic [7:0] therm(input int n);
        logic [8:0] t;
        t = (9'd1 << n) - 9'd1;
        return t[7:0];
    endfunction

    // Pulse trigger for one cycle; returns in the first LIGHTS cycle.
    task automatic start_seq();
        @(negedge clk);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        n_checks++;
        if (lights !== 8'h00 || busy !== 1'b1 || jump_start !== 1'b0) begin
            n_fail++;
            $display("FAIL start lights=%h busy=%b jump=%b exp 00/1/0", lights, busy, jump_start);
        end
    endtask

    // Walk 32 cycles of LIGHTS; optional trigger re-pulse at cycle retrig_at.
    task automatic run_lights(input int retrig_at, output logic [6:0] h);
        h = 7'd0;
        for (int k = 1; k <= 32; k++) begin
            if (k == retrig_at) trigger = 1'b1;
            @(negedge clk);
            trigger = 1'b0;
            n_checks++;
            if (lights !== therm(k / 4) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL lights_seq k=%0d lights=%h busy=%b exp %h/1", k, lights, busy, therm(k / 4));
            end
        end
        h = lfsr_pre;
    endtask

    // Hold phase of 4*h cycles; optionally press react on the releasing edge.
    task automatic run_hold(input logic [6:0] h, input bit jump_at_end);
        for (int c = 1; c < 4 * int'(h); c++) begin
            @(negedge clk);
            n_checks++;
            if (lights !== 8'hFF || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL hold c=%0d h=%0d lights=%h busy=%b exp FF/1", c, h, lights, busy);
            end
        end
        if (jump_at_end) react = 1'b1;
        @(negedge clk);
        react = 1'b0;
        n_checks++;
        if (jump_at_end) begin
            if (lights !== 8'h00 || jump_start !== 1'b1 || busy !== 1'b0 ||
                time_valid !== 1'b0 || react_time !== last_rt) begin
                n_fail++;
                $display("FAIL edge_jump lights=%h jump=%b busy=%b tv=%b rt=%0d exp 00/1/0/0/%0d",
                         lights, jump_start, busy, time_valid, react_time, last_rt);
            end
        end else if (lights !== 8'h00 || busy !== 1'b1 || jump_start !== 1'b0) begin
            n_fail++;
            $display("FAIL lights_out h=%0d lights=%h busy=%b jump=%b exp 00/1/0", h, lights, busy, jump_start);
        end
    endtask

    // In GO cycle 0: wait d cycles, press react, expect react_time=exp.
    task automatic go_react(input int d, input logic [15:0] exp);
        repeat (d) @(negedge clk);
        react = 1'b1;
        @(negedge clk);
        react = 1'b0;
        n_checks++;
        if (react_time !== exp || time_valid !== 1'b1 || busy !== 1'b0 || jump_start !== 1'b0) begin
            n_fail++;
            $display("FAIL react d=%0d rt=%0d tv=%b busy=%b jump=%b exp %0d/1/0/0",
                     d, react_time, time_valid, busy, jump_start, exp);
        end
        last_rt = exp;
        @(negedge clk);
        n_checks++;
        if (time_valid !== 1'b0 || react_time !== exp) begin
            n_fail++;
            $display("FAIL tv_pulse tv=%b rt=%0d exp 0/%0d", time_valid, react_time, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        trigger = 1'b1;
        react = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (lights !== 8'h00 || react_time !== 16'h0000 || time_valid !== 1'b0 ||
            jump_start !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset lights=%h rt=%h tv=%b jump=%b busy=%b exp all zero",
                     lights, react_time, time_valid, jump_start, busy);
        end
        rst = 1'b0;
        trigger = 1'b0;
        repeat (2) @(negedge clk);
        react = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || jump_start !== 1'b0 || react_time !== 16'h0000 || time_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_react busy=%b jump=%b rt=%h tv=%b exp 0/0/0/0",
                     busy, jump_start, react_time, time_valid);
        end
    endtask

    task automatic test_normal(input int iters);
        logic [6:0] h;
        int d;
        for (int i = 0; i < iters; i++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            start_seq();
            run_lights(0, h);
            run_hold(h, 1'b0);
            d = int'($urandom_range(0, 40));
            go_react(d, 16'(d));
        end
    endtask

    task automatic test_retrigger();
        logic [6:0] h;
        start_seq();
        run_lights(5, h);
        run_hold(h, 1'b0);
        go_react(7, 16'd7);
    endtask

    task automatic test_jump_start();
        logic [6:0] h;
        start_seq();
        repeat (12) @(negedge clk);
        n_checks++;
        if (lights !== 8'h07) begin
            n_fail++;
            $display("FAIL pre_jump lights=%h exp 07", lights);
        end
        react = 1'b1;
        @(negedge clk);
        n_checks++;
        if (lights !== 8'h00 || jump_start !== 1'b1 || busy !== 1'b0 ||
            time_valid !== 1'b0 || react_time !== last_rt) begin
            n_fail++;
            $display("FAIL jump lights=%h jump=%b busy=%b tv=%b rt=%0d exp 00/1/0/0/%0d",
                     lights, jump_start, busy, time_valid, react_time, last_rt);
        end
        // React held in DONE is ignored.
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || jump_start !== 1'b1 || time_valid !== 1'b0 || react_time !== last_rt) begin
            n_fail++;
            $display("FAIL done_react busy=%b jump=%b tv=%b rt=%0d exp 0/1/0/%0d",
                     busy, jump_start, time_valid, react_time, last_rt);
        end
        // Trigger with react in DONE: trigger wins, jump flag cleared.
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        react = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || jump_start !== 1'b0 || lights !== 8'h00) begin
            n_fail++;
            $display("FAIL done_trigger busy=%b jump=%b lights=%h exp 1/0/00", busy, jump_start, lights);
        end
        run_lights(0, h);
        run_hold(h, 1'b0);
        go_react(3, 16'd3);
    endtask

    task automatic test_edge_jump();
        logic [6:0] h;
        start_seq();
        run_lights(0, h);
        run_hold(h, 1'b1);
    endtask

    task automatic test_reset_mid_hold();
        logic [6:0] h;
        start_seq();
        run_lights(0, h);
        @(negedge clk);
        rst = 1'b1;
        trigger = 1'b1;
        react = 1'b1;
        @(negedge clk);
        n_checks++;
        if (lights !== 8'h00 || react_time !== 16'h0000 || time_valid !== 1'b0 ||
            jump_start !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset lights=%h rt=%h tv=%b jump=%b busy=%b exp all zero",
                     lights, react_time, time_valid, jump_start, busy);
        end
        rst = 1'b0;
        trigger = 1'b0;
        react = 1'b0;
        last_rt = 16'h0000;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || lights !== 8'h00) begin
            n_fail++;
            $display("FAIL post_reset busy=%b lights=%h exp 0/00", busy, lights);
        end
        start_seq();
        run_lights(0, h);
        run_hold(h, 1'b0);
        go_react(12, 16'd12);
    endtask

    task automatic test_saturation();
        logic [6:0] h;
        start_seq();
        run_lights(0, h);
        run_hold(h, 1'b0);
        go_react(65540, 16'hFFFF);
    endtask

    initial begin
        test_reset();
        test_normal(3);
        test_retrigger();
        test_jump_start();
        test_edge_jump();
        test_reset_mid_hold();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/f1_race_ctrl.md
F1_RACE_CTRL -- requirements
Module: f1_race_ctrl

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 16'd1000; clk cycles per light step and per hold unit; legal range 2..65535.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL provide port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL provide port trigger  input  1  start request, level-sampled, honoured only in IDLE or DONE.
REQ-005 SHALL provide port react  input  1  driver button, level-sampled; synchronised/debounced upstream.
REQ-006 SHALL provide port lights  output  8  start-light pattern, thermometer code (8'h00, 8'h01, 8'h03 … 8'hFF).
REQ-007 SHALL provide port react_time  output  16  clk cycles from lights-out to react, held until next start.
REQ-008 SHALL provide port time_valid  output  1  one-cycle pulse when react_time is updated.
REQ-009 SHALL provide port jump_start  output  1  sticky flag, react seen before lights-out.
REQ-010 SHALL provide port busy  output  1  high in LIGHTS, HOLD and GO.

Function
REQ-011 SHALL implement states IDLE, LIGHTS, HOLD, GO, DONE; busy = (state is LIGHTS, HOLD or GO).
REQ-012 SHALL run a tick counter 0..TICK_DIV-1, cleared on entry to LIGHTS and to HOLD; tick = counter at TICK_DIV-1.
REQ-013 SHALL free-run a 7-bit LFSR every cycle: next = {q[5:0], q[6]^q[2]}; reset value 7'h01; it never holds 0.
REQ-014 IDLE/DONE: trigger=1 -> LIGHTS next cycle; clear lights, jump_start, react counter; react_time holds until overwritten.
REQ-015 LIGHTS: each tick lights <= {lights[6:0],1'b1}; the first light appears exactly TICK_DIV cycles after LIGHTS entry.
REQ-016 LIGHTS: the tick that produces 8'hFF also moves to HOLD; hold counter <= current LFSR value (1..127).
REQ-017 HOLD: lights stay 8'hFF; each tick decrements the hold counter; the tick that reaches 0 moves to GO and sets lights to 8'h00 on the same edge.
REQ-018 GO: react counter starts at 0 on the cycle lights first read 8'h00; +1 per cycle; saturates at 16'hFFFF, no wrap.
REQ-019 GO with react=1: react_time <= react counter; time_valid=1 for exactly one cycle; -> DONE.
REQ-020 react=1 in LIGHTS or HOLD: jump_start <= 1, lights <= 8'h00, react_time unchanged, no time_valid; -> DONE next cycle.
REQ-021 react=1 on the same cycle the HOLD-to-GO transition fires: counts as a jump start (REQ-020 wins).
REQ-022 trigger while busy SHALL be ignored; react in IDLE or DONE SHALL be ignored.
REQ-023 trigger and react both high in DONE: trigger wins, react ignored.
REQ-024 SHALL register all outputs; there is no combinational path from input to output.

Reset
REQ-025 rst=1 SHALL force IDLE, lights=8'h00, react_time=16'h0000, time_valid=0, jump_start=0, busy=0, LFSR=7'h01, all counters 0, from any state including mid-sequence.
REQ-026 rst SHALL take priority over trigger and react on the same edge.

Verification (TICK_DIV=4)
REQ-027 reset, trigger 1 cycle -> lights 8'h01 4 cycles after LIGHTS entry, one bit per 4 cycles, 8'hFF after 32 cycles, busy=1 throughout.
REQ-028 normal start: HOLD length = 4 x captured LFSR value (compared against a bench LFSR model), then lights 8'h00; react asserted 10 cycles after lights-out -> react_time=16'd10, single time_valid pulse, busy=0.
REQ-029 react during lights 8'h07 -> next cycle lights=8'h00, jump_start=1, state DONE, no time_valid, react_time keeps the previous value.
REQ-030 no react in GO for more than 65535 cycles, then react -> react_time=16'hFFFF.
REQ-031 rst asserted during HOLD -> next cycle all outputs at reset values; a fresh trigger restarts from lights 8'h00.
REQ-032 trigger re-pulsed during LIGHTS -> sequence timing unchanged; trigger in DONE -> jump_start cleared and new sequence started.
